// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_responder_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_WAIT = 2'd1,
        RSP_RESP = 2'd2
    } dmem_rsp_state_t;

    // Request as captured in the IDLE cycle it was presented.
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } dmem_req_t;

    // True when addr lies in [base, base + span_bytes). Done in 33 bits so the
    // upper bound cannot wrap.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [32:0] span_bytes);
        logic [32:0] off;
        off = {1'b0, addr} - {1'b0, base};
        return (addr >= base) && (off < span_bytes);
    endfunction

endpackage

// File: rtl/dmem_responder_word_array.sv
// Word-addressed backing store: async clear, one byte-masked write port,
// one combinational read port.
module dmem_word_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [3:0]        wmask,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [31:0]       wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [31:0]       rdata
);

    logic [31:0] rd_words [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [31:0] word_q;
            logic [31:0] word_d;

            // Merge the enabled byte lanes of the write data into this word.
            always_comb begin
                word_d = word_q;
                if (we && (waddr == IDX_W'(gi))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wmask[b]) begin
                            word_d[8*b +: 8] = wdata[8*b +: 8];
                        end
                    end
                end
            end

            // Word storage, cleared by reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_q <= '0;
                end else begin
                    word_q <= word_d;
                end
            end

            assign rd_words[gi] = word_q;
        end
    endgenerate

    assign rdata = rd_words[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency responder for the pipeline data-memory port. Captures one
// request in IDLE, counts down the latency, then answers for one cycle.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h1ECE_B000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        busy,
    output logic        err
);

    localparam int          IDX_W    = $clog2(DEPTH);
    localparam logic [32:0] SPAN     = 33'(4 * DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    dmem_rsp_state_t state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    dmem_req_t       req_q, req_d;
    logic            err_q, err_d;

    logic             request;
    logic             req_in_range;
    logic             req_is_write;
    logic [IDX_W-1:0] req_idx;
    logic             arr_we;
    logic [31:0]      arr_rdata;

    assign request      = (|dmem_rmask) | (|dmem_wmask);
    assign req_in_range = addr_in_range(req_q.addr, BASE_ADDR, SPAN);
    assign req_is_write = |req_q.wmask;
    assign req_idx      = IDX_W'((req_q.addr - BASE_ADDR) >> 2);

    // Next-state logic: capture in IDLE, count down in WAIT, one-cycle RESP.
    // Requests arriving outside IDLE are dropped and flagged.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        err_d   = err_q;
        unique case (state_q)
            RSP_IDLE: begin
                if (request) begin
                    req_d.addr  = dmem_addr;
                    req_d.rmask = dmem_rmask;
                    req_d.wmask = dmem_wmask;
                    req_d.wdata = dmem_wdata;
                    cnt_d       = CNT_INIT;
                    state_d     = (LATENCY > 1) ? RSP_WAIT : RSP_RESP;
                    if (!addr_in_range(dmem_addr, BASE_ADDR, SPAN) ||
                        ((|dmem_rmask) && (|dmem_wmask))) begin
                        err_d = 1'b1;
                    end
                end
            end
            RSP_WAIT: begin
                if (request) begin
                    err_d = 1'b1;
                end
                if (cnt_q == 4'd1) begin
                    state_d = RSP_RESP;
                end
                cnt_d = cnt_q - 4'd1;
            end
            RSP_RESP: begin
                if (request) begin
                    err_d = 1'b1;
                end
                state_d = RSP_IDLE;
            end
            default: begin
                state_d = RSP_IDLE;
            end
        endcase
    end

    // Control registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RSP_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            err_q   <= err_d;
        end
    end

    // Writes land at the end of the RESP cycle; out-of-range writes vanish.
    assign arr_we = (state_q == RSP_RESP) && req_is_write && req_in_range;

    dmem_word_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (arr_we),
        .wmask (req_q.wmask),
        .waddr (req_idx),
        .wdata (req_q.wdata),
        .raddr (req_idx),
        .rdata (arr_rdata)
    );

    assign dmem_resp  = (state_q == RSP_RESP);
    assign busy       = (state_q == RSP_WAIT);
    assign err        = err_q;
    assign dmem_rdata = (dmem_resp && (|req_q.rmask) && !req_is_write && req_in_range)
                        ? arr_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed table, hand-written
// multi-cycle sequences and randomized traffic against a simple memory model.
module tb_dmem_responder;

    localparam int          DEPTH   = 256;
    localparam int          LATENCY = 2;
    localparam logic [31:0] BASE    = 32'h1ECE_B000;

    logic        clk;
    logic        rst_n;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        busy;
    logic        err;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // Reference model state.
    logic [31:0] model_mem [DEPTH];
    logic        model_err;

    dmem_responder #(
        .DEPTH     (DEPTH),
        .LATENCY   (LATENCY),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        model_err = 1'b0;
    endtask

    // Behavioural outcome of one accepted transaction.
    task automatic model_txn(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                             input logic [31:0] wd, output logic [31:0] rd);
        longint unsigned la, lb;
        bit in_rng;
        int idx;
        la = longint'(a);
        lb = longint'(BASE);
        in_rng = (la >= lb) && (la < lb + 4 * DEPTH);
        idx = in_rng ? int'((la - lb) / 4) : 0;
        rd = 32'h0;
        if (!in_rng || (rm != 0 && wm != 0)) model_err = 1'b1;
        if (wm != 0) begin
            if (in_rng)
                for (int b = 0; b < 4; b++)
                    if (wm[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
        end else if (in_rng) begin
            rd = model_mem[idx];
        end
    endtask

    task automatic clear_inputs();
        dmem_addr  = 32'h0;
        dmem_rmask = 4'h0;
        dmem_wmask = 4'h0;
        dmem_wdata = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    // One full transaction; returns DUT results plus model expectations.
    task automatic txn(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                       input logic [31:0] wd, output logic [31:0] rd, output logic e,
                       output logic [31:0] m_rd, output logic m_e);
        int lat;
        @(negedge clk);
        check("resp_idle", 32'(dmem_resp), 32'h0);
        dmem_addr  = a;
        dmem_rmask = rm;
        dmem_wmask = wm;
        dmem_wdata = wd;
        @(negedge clk);
        clear_inputs();
        lat = 1;
        while (!dmem_resp && lat <= 20) begin
            check("busy_wait", 32'(busy), 32'h1);
            check("rdata_wait", dmem_rdata, 32'h0);
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(LATENCY));
        check("busy_at_resp", 32'(busy), 32'h0);
        rd = dmem_rdata;
        e  = err;
        model_txn(a, rm, wm, wd, m_rd);
        m_e = model_err;
        $display("txn addr=%h rm=%h wm=%h wd=%h -> rdata=%h err=%0d lat=%0d", a, rm, wm, wd, rd, e, lat);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rm;
        logic [3:0]  wm;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [31:0] rd, m_rd;
        logic e, m_e;

        tbl[0]  = '{BASE + 32'd8,    4'hF, 4'h0, 32'h0,        32'h0,        1'b0, "rd_fresh"};
        tbl[1]  = '{BASE + 32'd4,    4'h0, 4'h6, 32'hDEADBEEF, 32'h0,        1'b0, "wr_mask6"};
        tbl[2]  = '{BASE + 32'd4,    4'hF, 4'h0, 32'h0,        32'h00ADBE00, 1'b0, "rd_mask6"};
        tbl[3]  = '{BASE + 32'd12,   4'h0, 4'hF, 32'h12345678, 32'h0,        1'b0, "wr_word3"};
        tbl[4]  = '{BASE + 32'd12,   4'h1, 4'h0, 32'h0,        32'h12345678, 1'b0, "rd_word3_b2b"};
        tbl[5]  = '{BASE + 32'd1021, 4'h0, 4'h1, 32'h000000AA, 32'h0,        1'b0, "wr_last"};
        tbl[6]  = '{BASE + 32'd1020, 4'hF, 4'h0, 32'h0,        32'h000000AA, 1'b0, "rd_last"};
        tbl[7]  = '{BASE + 32'd1024, 4'hF, 4'h0, 32'h0,        32'h0,        1'b1, "rd_oob_hi"};
        tbl[8]  = '{BASE - 32'd4,    4'hF, 4'h0, 32'h0,        32'h0,        1'b1, "rd_oob_lo"};
        tbl[9]  = '{BASE + 32'd4,    4'hF, 4'h3, 32'h00005555, 32'h0,        1'b1, "wr_both"};
        tbl[10] = '{BASE + 32'd4,    4'hF, 4'h0, 32'h0,        32'h00AD5555, 1'b1, "rd_both"};
        tbl[11] = '{BASE + 32'd1024, 4'h0, 4'hF, 32'hFFFFFFFF, 32'h0,        1'b1, "wr_oob"};
        tbl[12] = '{BASE,            4'hF, 4'h0, 32'h0,        32'h0,        1'b1, "rd_word0"};

        rst_n = 1'b0;
        clear_inputs();
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_resp", 32'(dmem_resp), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_rdata", dmem_rdata, 32'h0);
        rst_n = 1'b1;

        // Directed table.
        for (int i = 0; i < 13; i++) begin
            txn(tbl[i].addr, tbl[i].rm, tbl[i].wm, tbl[i].wd, rd, e, m_rd, m_e);
            check({tbl[i].name, "_rdata"}, rd, tbl[i].exp_rd);
            check({tbl[i].name, "_err"}, 32'(e), 32'(tbl[i].exp_err));
        end

        // Reset one cycle into WAIT abandons the read and clears the store.
        @(negedge clk);
        dmem_addr  = BASE + 32'd12;
        dmem_rmask = 4'hF;
        @(negedge clk);
        clear_inputs();
        check("pre_rst_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_resp", 32'(dmem_resp), 32'h0);
        check("async_rst_err", 32'(err), 32'h0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_resp_after_rst", 32'(dmem_resp), 32'h0);
        end
        txn(BASE + 32'd12, 4'hF, 4'h0, 32'h0, rd, e, m_rd, m_e);
        check("rd_after_rst", rd, 32'h0);
        check("err_after_rst", 32'(e), 32'h0);

        // Second request while busy: flagged, ignored, original completes.
        @(negedge clk);
        dmem_addr  = BASE + 32'd16;
        dmem_wmask = 4'hF;
        dmem_wdata = 32'hCAFEF00D;
        @(negedge clk);
        check("coll_busy", 32'(busy), 32'h1);
        check("coll_resp_early", 32'(dmem_resp), 32'h0);
        dmem_addr  = BASE + 32'd20;
        dmem_rmask = 4'hF;
        dmem_wmask = 4'h0;
        dmem_wdata = 32'h0;
        @(negedge clk);
        clear_inputs();
        check("coll_resp", 32'(dmem_resp), 32'h1);
        check("coll_err", 32'(err), 32'h1);
        check("coll_rdata", dmem_rdata, 32'h0);
        model_txn(BASE + 32'd16, 4'h0, 4'hF, 32'hCAFEF00D, m_rd);
        model_err = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("coll_no_second_resp", 32'(dmem_resp), 32'h0);
            check("coll_not_busy", 32'(busy), 32'h0);
        end
        txn(BASE + 32'd16, 4'hF, 4'h0, 32'h0, rd, e, m_rd, m_e);
        check("coll_readback", rd, 32'hCAFEF00D);
        check("coll_err_sticky", 32'(e), 32'h1);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 250; i++) begin
            logic [31:0] a, wd;
            logic [3:0]  rm, wm;
            int r, idx;
            r   = int'($urandom_range(0, 99));
            idx = (r < 15) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 15));
            a   = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
            if (r >= 97) begin
                if ($urandom_range(0, 1) == 1) a = BASE - 32'(4 * $urandom_range(1, 8));
                else                           a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 8));
            end
            wd = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                rm = 4'($urandom_range(1, 15));
                wm = 4'h0;
            end else begin
                wm = 4'($urandom_range(1, 15));
                rm = ($urandom_range(0, 29) == 0) ? 4'hF : 4'h0;
            end
            txn(a, rm, wm, wd, rd, e, m_rd, m_e);
            check("rand_rdata", rd, m_rd);
            check("rand_err", 32'(e), 32'(m_e));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
